// File: rtl/flap_game_ctrl.sv
// flap_game_ctrl: frame-stepped flappy-bird game FSM with gravity, pipe collision and scoring.
module flap_game_ctrl #(
  parameter int BIRD_X      = 240,
  parameter int BIRD_SZ     = 20,
  parameter int Y_START     = 240,
  parameter int Y_MIN       = 5,
  parameter int Y_MAX       = 455,
  parameter int FLAP_V      = -10,
  parameter int V_MAX       = 8,
  parameter int GRAV_DIV    = 2,
  parameter int PIPE_W      = 40,
  parameter int DEAD_FRAMES = 60
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       flap,
  input  logic       pause,
  input  logic [9:0] pipe_x,
  input  logic [9:0] gap_top,
  input  logic [9:0] gap_bot,
  output logic [9:0] bird_y,
  output logic [1:0] state,
  output logic [7:0] score,
  output logic       crash
);
  localparam int GW = $clog2(GRAV_DIV + 1);
  localparam int DW = $clog2(DEAD_FRAMES + 1);
  localparam logic signed [5:0]  FLAPV_S = 6'(FLAP_V);
  localparam logic signed [5:0]  VMAX_S  = 6'(V_MAX);
  localparam logic signed [10:0] YMIN_S  = 11'(Y_MIN);
  localparam logic signed [10:0] YMAX_S  = 11'(Y_MAX);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DEAD = 2'b10, BAD = 2'b11} st_t;
  st_t st_q, st_d;
  logic [9:0] y_q, y_d;
  logic signed [5:0] vel_q, vel_d, vel_n;
  logic [7:0] score_q, score_d;
  logic crash_q, crash_d, was_play_q, was_play_d, pend_q, pend_d;
  logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [GW-1:0] grav_q, grav_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [10:0] prev_q, prev_d, pedge;
  logic signed [10:0] ny;
  logic tick, rise, hit, gwrap, score_ev;
  always_comb begin
    tick = frame_tick & ~pause;
    rise = s2_q & ~s3_q & ~pause;
    pedge = {1'b0, pipe_x} + 11'(PIPE_W);
    hit = ({1'b0, pipe_x} < 11'(BIRD_X + BIRD_SZ)) && (pedge > 11'(BIRD_X)) &&
          ((y_q < gap_top) || ({1'b0, y_q} + 11'(BIRD_SZ) > {1'b0, gap_bot}));
    gwrap = grav_q == GW'(GRAV_DIV - 1);
    vel_n = pend_q ? FLAPV_S : !gwrap ? vel_q : (vel_q >= VMAX_S) ? VMAX_S : vel_q + 6'sd1;
    ny = $signed({1'b0, y_q}) + $signed({{5{vel_n[5]}}, vel_n});
    score_ev = (prev_q >= 11'(BIRD_X)) && (pedge < 11'(BIRD_X));
    s1_d = flap;
    s2_d = s1_q;
    s3_d = s2_q;
    pend_d = rise | (pend_q & ~tick);
    was_play_d = st_q == PLAY;
    crash_d = (st_q == DEAD) && was_play_q;
    st_d = st_q;
    y_d = y_q;
    vel_d = vel_q;
    score_d = score_q;
    grav_d = grav_q;
    dead_d = dead_q;
    prev_d = prev_q;
    case (st_q)
      IDLE: begin
        y_d = 10'(Y_START);
        vel_d = '0;
        if (tick && pend_q) begin
          st_d = PLAY;
          vel_d = FLAPV_S;
          grav_d = '0;
          score_d = '0;
        end
      end
      PLAY: if (tick) begin
        prev_d = pedge;
        if (hit) begin
          st_d = DEAD;
          dead_d = '0;
        end else begin
          vel_d = vel_n;
          grav_d = (pend_q || gwrap) ? '0 : grav_q + 1'b1;
          if (score_ev && score_q != 8'hFF) score_d = score_q + 8'd1;
          if (ny <= YMIN_S || ny >= YMAX_S) begin
            y_d = (ny <= YMIN_S) ? 10'(Y_MIN) : 10'(Y_MAX);
            st_d = DEAD;
            dead_d = '0;
          end else y_d = ny[9:0];
        end
      end
      DEAD: if (tick) begin
        if (dead_q == DW'(DEAD_FRAMES - 1)) begin
          st_d = IDLE;
          dead_d = '0;
          y_d = 10'(Y_START);
          vel_d = '0;
          pend_d = 1'b0;
        end else dead_d = dead_q + 1'b1;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      st_q <= IDLE;
      y_q <= 10'(Y_START);
      vel_q <= '0;
      score_q <= '0;
      crash_q <= 1'b0;
      was_play_q <= 1'b0;
      pend_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      grav_q <= '0;
      dead_q <= '0;
      prev_q <= '0;
    end else begin
      st_q <= st_d;
      y_q <= y_d;
      vel_q <= vel_d;
      score_q <= score_d;
      crash_q <= crash_d;
      was_play_q <= was_play_d;
      pend_q <= pend_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      grav_q <= grav_d;
      dead_q <= dead_d;
      prev_q <= prev_d;
    end
  end
  assign bird_y = y_q;
  assign state = st_q;
  assign score = score_q;
  assign crash = crash_q;
endmodule

// File: tb/tb_flap_game_ctrl.sv
// tb_flap_game_ctrl: directed vectors and multi-cycle sequences for flap_game_ctrl.
module tb_flap_game_ctrl;
  logic dclk = 1'b0, clr = 1'b1, frame_tick = 1'b0, flap = 1'b0, pause = 1'b0;
  logic [9:0] pipe_x = 10'd1000, gap_top = 10'd0, gap_bot = 10'd0;
  logic [9:0] bird_y;
  logic [1:0] state;
  logic [7:0] score;
  logic crash;
  int passed = 0, total = 0, crash_n = 0;
  typedef struct {int px; int gt; int gb; int y; int st; int sc;} vec_t;
  vec_t tbl[6];
  flap_game_ctrl dut (
    .dclk(dclk), .clr(clr), .frame_tick(frame_tick), .flap(flap), .pause(pause),
    .pipe_x(pipe_x), .gap_top(gap_top), .gap_bot(gap_bot),
    .bird_y(bird_y), .state(state), .score(score), .crash(crash)
  );
  always #20 dclk = ~dclk;
  always @(negedge dclk) if (crash) crash_n <= crash_n + 1;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge dclk);
  endtask
  task automatic tick();
    @(negedge dclk);
    frame_tick = 1'b1;
    @(negedge dclk);
    frame_tick = 1'b0;
  endtask
  task automatic flap_pulse();
    @(negedge dclk);
    flap = 1'b1;
    cycles(3);
    flap = 1'b0;
    cycles(3);
  endtask
  task automatic chk_out(input string name, input int y, input int st, input int sc);
    chk({name, " bird_y"}, int'(bird_y), y);
    chk({name, " state"}, int'(state), st);
    chk({name, " score"}, int'(score), sc);
  endtask
  initial begin
    int c0, y, v, g, ny;
    bit dead;
    tbl[0] = '{260, 300, 310, 230, 1, 0};
    tbl[1] = '{200, 300, 310, 221, 1, 0};
    tbl[2] = '{199, 300, 310, 212, 1, 1};
    tbl[3] = '{600, 300, 310, 204, 1, 1};
    tbl[4] = '{201, 196, 224, 196, 1, 1};
    tbl[5] = '{259, 197, 300, 196, 2, 1};
    cycles(3);
    chk_out("reset", 240, 0, 0);
    chk("reset crash", int'(crash), 0);
    clr = 1'b0;
    tick();
    chk("idle tick no flap state", int'(state), 0);
    flap_pulse();
    tick();
    chk_out("start", 240, 1, 0);
    foreach (tbl[i]) begin
      @(negedge dclk);
      pipe_x = 10'(tbl[i].px);
      gap_top = 10'(tbl[i].gt);
      gap_bot = 10'(tbl[i].gb);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].y, tbl[i].st, tbl[i].sc);
    end
    chk("collision crash low at entry", int'(crash), 0);
    c0 = crash_n;
    cycles(4);
    chk("collision crash pulses", crash_n - c0, 1);
    pipe_x = 10'd1000;
    repeat (58) tick();
    flap_pulse();
    tick();
    chk_out("dead 59 ticks", 196, 2, 1);
    tick();
    chk_out("dead to idle", 240, 0, 1);
    tick();
    chk("idle pend cleared", int'(state), 0);
    flap_pulse();
    tick();
    chk_out("game2 start", 240, 1, 0);
    y = 240; v = -10; g = 0; dead = 0;
    c0 = crash_n;
    for (int i = 0; i < 100 && !dead; i++) begin
      if (g == 1) begin
        g = 0;
        v = (v >= 8) ? 8 : v + 1;
      end else g++;
      ny = y + v;
      if (ny >= 455) begin
        y = 455;
        dead = 1;
      end else y = ny;
      tick();
      chk($sformatf("fall%0d bird_y", i), int'(bird_y), y);
      chk($sformatf("fall%0d state", i), int'(state), dead ? 2 : 1);
      if (i == 0) begin
        chk("first move bird_y", int'(bird_y), 230);
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
          if (k % 4 == 0) flap_pulse();
          tick();
        end
        cycles(4);
        chk_out("paused", 230, 1, 0);
        pause = 1'b0;
        cycles(2);
      end
    end
    if (!dead) chk("fall reached floor", 0, 1);
    chk_out("floor", 455, 2, 0);
    cycles(4);
    chk("floor crash pulses", crash_n - c0, 1);
    repeat (5) tick();
    c0 = crash_n;
    #7 clr = 1'b1;
    #1;
    chk_out("clr mid-dead", 240, 0, 0);
    chk("clr mid-dead crash", int'(crash), 0);
    cycles(3);
    clr = 1'b0;
    cycles(3);
    chk("clr no crash", crash_n - c0, 0);
    flap_pulse();
    tick();
    chk_out("game3 start", 240, 1, 0);
    c0 = crash_n;
    for (int k = 1; k <= 24; k++) begin
      flap_pulse();
      tick();
      chk($sformatf("climb%0d bird_y", k), int'(bird_y), k < 24 ? 240 - 10 * k : 5);
      chk($sformatf("climb%0d state", k), int'(state), k < 24 ? 1 : 2);
    end
    cycles(4);
    chk("ceiling crash pulses", crash_n - c0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
